// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory req/ack port,
// decode valid/ready port and queue occupancy.
interface ifetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          redirect;
    logic [63:0]   redirect_pc;
    logic          mem_req;
    logic [63:0]   mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic          dec_valid;
    logic [63:0]   dec_pc;
    logic [31:0]   dec_inst;
    logic          dec_ready;
    logic [CW-1:0] count;

    // Fetch-queue side
    modport master (
        input  redirect, redirect_pc, mem_ack, mem_rdata, dec_ready,
        output mem_req, mem_addr, dec_valid, dec_pc, dec_inst, count
    );

    // Memory / decode / branch-resolution side
    modport slave (
        output redirect, redirect_pc, mem_ack, mem_rdata, dec_ready,
        input  mem_req, mem_addr, dec_valid, dec_pc, dec_inst, count
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: single-outstanding fetch FSM feeding a DEPTH-entry
// {pc, inst} prefetch FIFO; a redirect flushes the FIFO and restarts fetching.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic           clk,
    input  logic           reset,
    ifetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   pend_q, pend_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   pc_mem_q   [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];

    logic push_c;
    logic pop_c;

    // FIFO bookkeeping; a redirect flush overrides any push or pop
    always_comb begin
        pop_c    = (count_q != '0) & bus.dec_ready;
        push_c   = (state_q == S_REQ) & bus.mem_ack & ~bus.redirect;
        rd_ptr_d = rd_ptr_q + PW'(pop_c);
        wr_ptr_d = wr_ptr_q + PW'(push_c);
        count_d  = count_q + CW'(push_c) - CW'(pop_c);
        if (bus.redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Fetch FSM: REQ is only entered or held while a queue slot is reserved
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.redirect) begin
                    addr_d  = bus.redirect_pc;
                    state_d = S_REQ;
                end else if ((count_q != CW'(DEPTH)) || pop_c) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.redirect) begin
                    if (bus.mem_ack) begin
                        addr_d = bus.redirect_pc;
                    end else begin
                        pend_d  = bus.redirect_pc;
                        state_d = S_DROP;
                    end
                end else if (bus.mem_ack) begin
                    addr_d = addr_q + 64'd4;
                    if (count_d == CW'(DEPTH)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (bus.mem_ack) begin
                    addr_d  = bus.redirect ? bus.redirect_pc : pend_q;
                    state_d = S_REQ;
                end else if (bus.redirect) begin
                    pend_d = bus.redirect_pc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= RESET_PC;
            pend_q   <= 64'd0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            pend_q   <= pend_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; the fetched PC is the outstanding request address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_mem_q   <= '{default: '0};
            inst_mem_q <= '{default: '0};
        end else if (push_c) begin
            pc_mem_q[wr_ptr_q]   <= addr_q;
            inst_mem_q[wr_ptr_q] <= bus.mem_rdata;
        end
    end

    assign bus.mem_req   = (state_q != S_IDLE);
    assign bus.mem_addr  = addr_q;
    assign bus.dec_valid = (count_q != '0);
    assign bus.dec_pc    = pc_mem_q[rd_ptr_q];
    assign bus.dec_inst  = inst_mem_q[rd_ptr_q];
    assign bus.count     = count_q;

endmodule
